// File: rtl/vga_frame_sequencer.sv
// vga_frame_sequencer
//   Frame-animation controller for the VGA display path. Produces the frame
//   index that selects the VRAM bank feeding the pixel pipeline. A period
//   timer (or a manual step while paused) raises a pending advance. That
//   advance is only applied on frame_start (start of vertical blank), so a
//   bank switch never tears mid-frame.
//
// Ports
//   pclk        pixel clock
//   rstn        asynchronous active-low reset
//   en          play enable; low forces IDLE and frame 0
//   mode        00 loop, 01 ping-pong, 10 one-shot, 11 loop
//   pause       level; freezes the period timer
//   step        one-cycle pulse; requests one advance while paused
//   period      pclk cycles per frame (0 behaves as 1)
//   frame_start one-cycle pulse at start of vertical blank
//   frame_sel   current frame index (0..N_FRAMES-1)
//   dir         ping-pong direction, 1 = descending
//   wrap        one-cycle pulse when a lap completes
//   done        sticky one-shot completion flag
module vga_frame_sequencer #(
    parameter int N_FRAMES = 10,
    parameter int FW       = 4,
    parameter int TW       = 26
) (
    input  logic          pclk,
    input  logic          rstn,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic          pause,
    input  logic          step,
    input  logic [TW-1:0] period,
    input  logic          frame_start,
    output logic [FW-1:0] frame_sel,
    output logic          dir,
    output logic          wrap,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_PAUSED,
        S_DONE
    } state_t;

    localparam logic [FW-1:0] LAST      = FW'(N_FRAMES - 1);
    // Turn-around target for ping-pong. It is unused when N_FRAMES == 1,
    // because that case is handled separately.
    localparam logic [FW-1:0] PREV_LAST = (N_FRAMES > 1) ? FW'(N_FRAMES - 2) : '0;

    state_t        state_q,   state_d;
    logic [FW-1:0] frame_q,   frame_d;
    logic          dir_q,     dir_d;
    logic          wrap_q,    wrap_d;
    logic          done_q,    done_d;
    logic [TW-1:0] timer_q,   timer_d;
    logic          pending_q, pending_d;

    logic [TW-1:0] eff_m1;
    logic          expire;
    logic          step_req;
    logic          apply;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        dir_d     = dir_q;
        wrap_d    = 1'b0;
        done_d    = done_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        expire    = 1'b0;
        step_req  = 1'b0;
        apply     = 1'b0;

        // A zero period behaves like a period of one, so it expires every cycle.
        eff_m1 = (period == '0) ? '0 : period - TW'(1);

        if (!en) begin
            state_d   = S_IDLE;
            frame_d   = '0;
            dir_d     = 1'b0;
            done_d    = 1'b0;
            timer_d   = '0;
            pending_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = pause ? S_PAUSED : S_PLAY;
                    timer_d   = '0;
                    pending_d = 1'b0;
                end
                S_PLAY, S_PAUSED: begin
                    state_d = pause ? S_PAUSED : S_PLAY;

                    // The ">=" comparison makes a lowered period expire on
                    // the very next cycle instead of wrapping the counter.
                    if (state_q == S_PLAY) begin
                        if (timer_q >= eff_m1) begin
                            timer_d = '0;
                            expire  = 1'b1;
                        end else begin
                            timer_d = timer_q + TW'(1);
                        end
                    end

                    step_req = (state_q == S_PAUSED) && step;
                    apply    = pending_q && frame_start;

                    // Requests collapse into one pending flag. A request that
                    // arrives in the same cycle as an application re-arms the
                    // flag, so it is not lost.
                    pending_d = (pending_q && !apply) || expire || step_req;

                    if (apply) begin
                        case (mode)
                            2'b01: begin
                                if (N_FRAMES == 1) begin
                                    frame_d = '0;
                                    dir_d   = 1'b0;
                                    wrap_d  = 1'b1;
                                end else if (!dir_q) begin
                                    if (frame_q == LAST) begin
                                        frame_d = PREV_LAST;
                                        dir_d   = 1'b1;
                                    end else begin
                                        frame_d = frame_q + FW'(1);
                                    end
                                end else begin
                                    if (frame_q == '0) begin
                                        frame_d = FW'(1);
                                        dir_d   = 1'b0;
                                        wrap_d  = 1'b1;
                                    end else begin
                                        frame_d = frame_q - FW'(1);
                                    end
                                end
                            end
                            2'b10: begin
                                dir_d = 1'b0;
                                if (frame_q == LAST) begin
                                    wrap_d  = 1'b1;
                                    done_d  = 1'b1;
                                    state_d = S_DONE;
                                end else begin
                                    frame_d = frame_q + FW'(1);
                                end
                            end
                            default: begin
                                dir_d = 1'b0;
                                if (frame_q == LAST) begin
                                    frame_d = '0;
                                    wrap_d  = 1'b1;
                                end else begin
                                    frame_d = frame_q + FW'(1);
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    // DONE holds the last frame until en drops.
                    state_d   = S_DONE;
                    pending_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            dir_q     <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            timer_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            dir_q     <= dir_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
        end
    end

    assign frame_sel = frame_q;
    assign dir       = dir_q;
    assign wrap      = wrap_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Scoreboard bench for vga_frame_sequencer. There are three instances
// (N_FRAMES = 10, 4 and 3). They share the control inputs and have separate
// enables, so only one instance is active at a time. Stimulus pushes the
// expected output changes. The monitor pops one entry each time an instance's
// {frame_sel, dir, wrap, done} changes.
module tb_vga_frame_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en10, en4, en3;
    logic [1:0]  mode;
    logic        pause;
    logic        step;
    logic [25:0] period;
    logic        frame_start;

    logic [3:0]  f10, f4, f3;
    logic        d10, d4, d3;
    logic        w10, w4, w3;
    logic        dn10, dn4, dn3;

    always #5 clk = ~clk;

    vga_frame_sequencer #(.N_FRAMES(10), .FW(4), .TW(26)) u10 (
        .pclk(clk), .rstn(rstn), .en(en10), .mode(mode), .pause(pause),
        .step(step), .period(period), .frame_start(frame_start),
        .frame_sel(f10), .dir(d10), .wrap(w10), .done(dn10)
    );

    vga_frame_sequencer #(.N_FRAMES(4), .FW(4), .TW(26)) u4 (
        .pclk(clk), .rstn(rstn), .en(en4), .mode(mode), .pause(pause),
        .step(step), .period(period), .frame_start(frame_start),
        .frame_sel(f4), .dir(d4), .wrap(w4), .done(dn4)
    );

    vga_frame_sequencer #(.N_FRAMES(3), .FW(4), .TW(26)) u3 (
        .pclk(clk), .rstn(rstn), .en(en3), .mode(mode), .pause(pause),
        .step(step), .period(period), .frame_start(frame_start),
        .frame_sel(f3), .dir(d3), .wrap(w3), .done(dn3)
    );

    typedef struct packed {
        logic [1:0] inst;
        logic [6:0] val;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    logic       mon_on = 1'b0;
    logic [6:0] prev [3];
    logic [6:0] cur  [3];

    initial begin
        for (int k = 0; k < 3; k++) prev[k] = '0;
    end

    // Monitor: a change on any instance's outputs consumes one scoreboard entry.
    always @(negedge clk) begin
        if (mon_on) begin
            cur[0] = {f10, d10, w10, dn10};
            cur[1] = {f4,  d4,  w4,  dn4};
            cur[2] = {f3,  d3,  w3,  dn3};
            for (int i = 0; i < 3; i++) begin
                if (cur[i] !== prev[i]) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change inst=%0d got {f,d,w,dn}=%h required no change",
                                 i, cur[i]);
                    end else begin
                        mon_e = sb_q.pop_front();
                        if (mon_e.inst != 2'(i) || mon_e.val !== cur[i]) begin
                            errors++;
                            $display("FAIL sequence inst=%0d got {f,d,w,dn}=%h required inst=%0d {f,d,w,dn}=%h",
                                     i, cur[i], mon_e.inst, mon_e.val);
                        end
                    end
                    prev[i] = cur[i];
                end
            end
        end
    end

    task automatic push(input int inst, input int f, input bit d, input bit w, input bit dn);
        exp_t e;
        e.inst = 2'(inst);
        e.val  = {4'(f), d, w, dn};
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frames(input int n, input int gap);
        repeat (n) begin
            cyc(gap - 1);
            frame_start = 1'b1;
            cyc(1);
            frame_start = 1'b0;
        end
    endtask

    initial begin
        rstn = 1'b0; en10 = 1'b0; en4 = 1'b0; en3 = 1'b0;
        mode = 2'b00; pause = 1'b0; step = 1'b0; period = 26'd4; frame_start = 1'b0;
        cyc(3);
        chk("reset_frame_sel", int'(f10), 0);
        chk("reset_dir", int'(d10), 0);
        chk("reset_wrap", int'(w10), 0);
        chk("reset_done", int'(dn10), 0);
        rstn = 1'b1;
        cyc(2);
        mon_on = 1'b1;

        // Loop, N=10, period 4: 0..9 then wrap back to 0.
        for (int f = 1; f <= 9; f++) push(0, f, 0, 0, 0);
        push(0, 0, 0, 1, 0);
        push(0, 0, 0, 0, 0);
        mode = 2'b00; period = 26'd4; en10 = 1'b1;
        run_frames(10, 10);
        cyc(15);
        en10 = 1'b0;
        cyc(3);

        // Ping-pong, N=4, period 2: 1,2,3,2,1,0,1. Wrap only on 0->1.
        push(1, 1, 0, 0, 0); push(1, 2, 0, 0, 0); push(1, 3, 0, 0, 0);
        push(1, 2, 1, 0, 0); push(1, 1, 1, 0, 0); push(1, 0, 1, 0, 0);
        push(1, 1, 0, 1, 0); push(1, 1, 0, 0, 0);
        push(1, 0, 0, 0, 0);
        mode = 2'b01; period = 26'd2; en4 = 1'b1;
        run_frames(7, 10);
        cyc(5);
        en4 = 1'b0;
        cyc(3);

        // One-shot, N=3: 1,2, then done with frame held. Toggling en clears it.
        push(2, 1, 0, 0, 0); push(2, 2, 0, 0, 0);
        push(2, 2, 0, 1, 1); push(2, 2, 0, 0, 1);
        push(2, 0, 0, 0, 0);
        push(2, 1, 0, 0, 0);
        push(2, 0, 0, 0, 0);
        mode = 2'b10; period = 26'd2; en3 = 1'b1;
        run_frames(5, 10);
        chk("oneshot_done_sticky", int'(dn3), 1);
        chk("oneshot_hold_frame", int'(f3), 2);
        en3 = 1'b0;
        cyc(1);
        chk("oneshot_en_clear_done", int'(dn3), 0);
        cyc(2);
        en3 = 1'b1;
        run_frames(1, 10);
        cyc(2);
        en3 = 1'b0;
        cyc(3);

        // Pause: frame_starts while paused give no advance. One step gives
        // exactly one advance. A step while disabled is ignored.
        push(0, 1, 0, 0, 0);
        push(0, 0, 0, 0, 0);
        mode = 2'b00; period = 26'd4; pause = 1'b1; en10 = 1'b1;
        run_frames(10, 10);
        chk("paused_frame_const", int'(f10), 0);
        step = 1'b1; cyc(1); step = 1'b0;
        run_frames(3, 10);
        chk("step_one_advance", int'(f10), 1);
        en10 = 1'b0;
        cyc(2);
        step = 1'b1; cyc(1); step = 1'b0;
        cyc(1);
        en10 = 1'b1;
        run_frames(3, 10);
        chk("step_ignored_idle", int'(f10), 0);
        en10 = 1'b0; pause = 1'b0;
        cyc(3);

        // Pending collapse with period 1, then with period 0.
        for (int f = 1; f <= 5; f++) push(0, f, 0, 0, 0);
        mode = 2'b00; period = 26'd1; en10 = 1'b1;
        run_frames(3, 20);
        period = 26'd0;
        run_frames(2, 20);

        // Asynchronous reset mid-count at frame 5.
        push(0, 0, 0, 0, 0);
        period = 26'd4;
        cyc(6);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_frame_sel", int'(f10), 0);
        chk("async_rst_dir", int'(d10), 0);
        chk("async_rst_wrap", int'(w10), 0);
        chk("async_rst_done", int'(dn10), 0);
        en10 = 1'b0;
        cyc(2);
        rstn = 1'b1;
        cyc(2);

        // Ping-pong N=10 to frame 7 descending, then en drops with a stale pending.
        for (int f = 1; f <= 9; f++) push(0, f, 0, 0, 0);
        push(0, 8, 1, 0, 0);
        push(0, 7, 1, 0, 0);
        push(0, 0, 0, 0, 0);
        mode = 2'b01; period = 26'd4; en10 = 1'b1;
        run_frames(11, 10);
        chk("pp_dir_at_7", int'(d10), 1);
        cyc(8);
        en10 = 1'b0; frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
        chk("en_abort_frame_sel", int'(f10), 0);
        chk("en_abort_dir", int'(d10), 0);
        cyc(2);
        en10 = 1'b1;
        cyc(1);
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
        cyc(1);
        chk("no_stale_advance", int'(f10), 0);
        en10 = 1'b0;
        cyc(20);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d leftover required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
